// File: rtl/tick_gen.sv
// Multi-rate tick generator: a prescaler produces tick_fast, a half-second
// counter derives tick_2hz, blink and tick_1hz from it. All outputs registered.
module tick_gen #(
    parameter int CLOCK_FREQ = 125000000,
    parameter int FAST_HZ    = 1000,
    parameter int SIM_DIV    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic sync,
    input  logic fast_mode,
    output logic tick_fast,
    output logic tick_2hz,
    output logic tick_1hz,
    output logic blink
);

    localparam int PARAMS_OK = ((FAST_HZ >= 2) && (FAST_HZ % 2 == 0) && (SIM_DIV >= 1)) ? 1 : 0;
    localparam int SAFE_HZ   = (FAST_HZ >= 1) ? FAST_HZ : 1;
    localparam int PRE_DIV   = CLOCK_FREQ / SAFE_HZ;
    localparam int HALF      = FAST_HZ / 2;
    localparam int MAX_DIV   = (PRE_DIV > SIM_DIV) ? PRE_DIV : SIM_DIV;
    localparam int PW        = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int HW        = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [PW-1:0] PRE_TERM  = PW'(PRE_DIV - 1);
    localparam logic [PW-1:0] SIM_TERM  = PW'(SIM_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
    localparam logic [HW-1:0] HALF_ONE  = HW'(1);

    if ((PARAMS_OK == 0) || (CLOCK_FREQ % SAFE_HZ != 0)) begin : g_bad_params
        $error("tick_gen: illegal CLOCK_FREQ/FAST_HZ/SIM_DIV combination");
    end

    logic [PW-1:0] r_pre;
    logic [HW-1:0] r_half;
    logic          r_blink;
    logic          r_tick_fast;
    logic          r_tick_2hz;
    logic          r_tick_1hz;

    logic [PW-1:0] w_term;
    logic          w_pre_wrap;
    logic          w_half_wrap;

    // Terminal is re-selected every cycle; >= lets a shrinking terminal wrap at once.
    always_comb begin
        w_term      = PRE_TERM;
        w_pre_wrap  = 1'b0;
        w_half_wrap = 1'b0;
        if (fast_mode) begin
            w_term = SIM_TERM;
        end else begin
            w_term = PRE_TERM;
        end
        w_pre_wrap  = (r_pre >= w_term);
        w_half_wrap = w_pre_wrap && (r_half == HALF_LAST);
    end

    // Counter and pulse registers; priority rst > sync > run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre       <= '0;
            r_half      <= '0;
            r_blink     <= 1'b0;
            r_tick_fast <= 1'b0;
            r_tick_2hz  <= 1'b0;
            r_tick_1hz  <= 1'b0;
        end else if (sync) begin
            r_pre       <= '0;
            r_half      <= '0;
            r_blink     <= 1'b0;
            r_tick_fast <= 1'b0;
            r_tick_2hz  <= 1'b0;
            r_tick_1hz  <= 1'b0;
        end else if (run) begin
            r_tick_fast <= w_pre_wrap;
            r_tick_2hz  <= w_half_wrap;
            // tick_1hz marks the half-second wrap where blink falls.
            r_tick_1hz  <= w_half_wrap && r_blink;
            if (w_pre_wrap) begin
                r_pre <= '0;
                if (w_half_wrap) begin
                    r_half  <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_half  <= r_half + HALF_ONE;
                    r_blink <= r_blink;
                end
            end else begin
                r_pre   <= r_pre + PRE_ONE;
                r_half  <= r_half;
                r_blink <= r_blink;
            end
        end else begin
            r_pre       <= r_pre;
            r_half      <= r_half;
            r_blink     <= r_blink;
            r_tick_fast <= 1'b0;
            r_tick_2hz  <= 1'b0;
            r_tick_1hz  <= 1'b0;
        end
    end

    assign tick_fast = r_tick_fast;
    assign tick_2hz  = r_tick_2hz;
    assign tick_1hz  = r_tick_1hz;
    assign blink     = r_blink;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with CLOCK_FREQ=1000, FAST_HZ=10, SIM_DIV=2
// (PRE_DIV=100, HALF=5); expected pulse counts and positions are hand-computed.
module tb_tick_gen;

    logic clk;
    logic rst;
    logic run;
    logic sync;
    logic fast_mode;
    logic tick_fast;
    logic tick_2hz;
    logic tick_1hz;
    logic blink;

    int n_tests;
    int n_fail;
    int cnt_fast;
    int cnt_2hz;
    int cnt_1hz;
    int first_fast;

    tick_gen #(
        .CLOCK_FREQ(1000),
        .FAST_HZ   (10),
        .SIM_DIV   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .sync     (sync),
        .fast_mode(fast_mode),
        .tick_fast(tick_fast),
        .tick_2hz (tick_2hz),
        .tick_1hz (tick_1hz),
        .blink    (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after each, tallying pulses.
    task automatic run_cycles(input int n);
        cnt_fast   = 0;
        cnt_2hz    = 0;
        cnt_1hz    = 0;
        first_fast = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (tick_fast === 1'b1) begin
                cnt_fast++;
                if (first_fast == 0) first_fast = i;
            end
            if (tick_2hz === 1'b1) cnt_2hz++;
            if (tick_1hz === 1'b1) cnt_1hz++;
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        run       = 1'b1;
        sync      = 1'b0;
        fast_mode = 1'b0;

        // Reset state
        run_cycles(3);
        check("rst_tick_fast", int'(tick_fast), 0);
        check("rst_tick_2hz", int'(tick_2hz), 0);
        check("rst_tick_1hz", int'(tick_1hz), 0);
        check("rst_blink", int'(blink), 0);
        check("rst_no_ticks", cnt_fast + cnt_2hz + cnt_1hz, 0);

        // Normal mode: tick_fast at edge 100, tick_2hz at 500, tick_1hz at 1000
        rst = 1'b0;
        run_cycles(100);
        check("norm_first_fast", first_fast, 100);
        check("norm_cnt_fast_100", cnt_fast, 1);
        check("norm_no_2hz_100", cnt_2hz, 0);
        run_cycles(400);
        check("norm_cnt_fast_500", cnt_fast, 4);
        check("norm_tick_fast_500", int'(tick_fast), 1);
        check("norm_tick_2hz_500", int'(tick_2hz), 1);
        check("norm_tick_1hz_500", int'(tick_1hz), 0);
        check("norm_blink_500", int'(blink), 1);
        run_cycles(500);
        check("norm_cnt_fast_1000", cnt_fast, 5);
        check("norm_cnt_2hz_1000", cnt_2hz, 1);
        check("norm_tick_2hz_1000", int'(tick_2hz), 1);
        check("norm_tick_1hz_1000", int'(tick_1hz), 1);
        check("norm_blink_1000", int'(blink), 0);

        // Pause at prescaler 40 for 37 cycles; next tick 60 cycles after resume
        run_cycles(40);
        check("pause_pre_no_tick", cnt_fast, 0);
        run = 1'b0;
        run_cycles(37);
        check("pause_no_ticks", cnt_fast + cnt_2hz + cnt_1hz, 0);
        run = 1'b1;
        run_cycles(60);
        check("resume_first_fast", first_fast, 60);
        check("resume_cnt_fast", cnt_fast, 1);

        // Prescaler at 50, switch to fast mode: wrap next edge, then every 2
        run_cycles(50);
        check("switch_pre_no_tick", cnt_fast, 0);
        fast_mode = 1'b1;
        run_cycles(1);
        check("switch_wrap_now", int'(tick_fast), 1);
        run_cycles(2);
        check("switch_next_first", first_fast, 2);
        check("switch_next_cnt", cnt_fast, 1);
        run_cycles(4);
        check("switch_cnt_fast", cnt_fast, 2);
        check("switch_tick_2hz", int'(tick_2hz), 1);
        check("switch_tick_1hz", int'(tick_1hz), 0);
        check("switch_blink", int'(blink), 1);

        // Fast mode: 20 cycles give 10 tick_fast, 2 tick_2hz, 1 tick_1hz
        run_cycles(20);
        check("fast_cnt_fast", cnt_fast, 10);
        check("fast_cnt_2hz", cnt_2hz, 2);
        check("fast_cnt_1hz", cnt_1hz, 1);
        check("fast_blink_end", int'(blink), 1);

        // Sync with run=0 at prescaler 70, blink=1
        fast_mode = 1'b0;
        run_cycles(70);
        check("sync_pre_no_tick", cnt_fast, 0);
        check("sync_pre_blink", int'(blink), 1);
        run  = 1'b0;
        sync = 1'b1;
        run_cycles(1);
        check("sync_blink_clear", int'(blink), 0);
        check("sync_ticks_zero", int'(tick_fast) + int'(tick_2hz) + int'(tick_1hz), 0);
        sync = 1'b0;
        run  = 1'b1;
        run_cycles(100);
        check("sync_first_fast", first_fast, 100);
        check("sync_cnt_fast", cnt_fast, 1);

        // rst with sync and run at the edge where a wrap would otherwise fire
        run_cycles(99);
        check("rst_pre_no_tick", cnt_fast, 0);
        rst  = 1'b1;
        sync = 1'b1;
        run_cycles(1);
        check("rstsync_tick_fast", int'(tick_fast), 0);
        check("rstsync_blink", int'(blink), 0);
        rst  = 1'b0;
        sync = 1'b0;
        run_cycles(100);
        check("rstsync_first_fast", first_fast, 100);
        check("rstsync_no_2hz", cnt_2hz, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
